pipe_control_unit: RTL and testbench

//  Parametrised ID-stage control for the 5-stage MIPS pipeline. Decodes the ID instruction
//  and registers the control bundle into the ID/EX boundary. Adds ADDI, SLT, optional

---
 rtl/pipe_control_unit_pkg.sv | 27 ++
 rtl/pipe_control_unit_if.sv | 32 +++
 rtl/pipe_control_unit_control_decode.sv | 68 ++++++
 rtl/pipe_control_unit.sv | 122 ++++++++++++
 tb/tb_pipe_control_unit.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_control_unit_pkg.sv
// Shared decode constants for the ID-stage control unit: opcodes, funct codes,
// EXE function codes, branch kinds and FSM states.
package pipe_control_unit_pkg;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_MUL = 6'b011000;

  typedef enum logic [2:0] {
    EXE_ADD = 3'd0, EXE_SUB = 3'd1, EXE_AND = 3'd2,
    EXE_OR  = 3'd3, EXE_SLT = 3'd4, EXE_MUL = 3'd5
  } exe_func_e;

  typedef enum logic [1:0] {BR_NONE = 2'd0, BR_JMP = 2'd1, BR_BEQ = 2'd2, BR_BNE = 2'd3} br_e;

  typedef enum logic {ST_RUN = 1'b0, ST_MUL_WAIT = 1'b1} state_e;
endpackage

// File: rtl/pipe_control_unit_if.sv
// IF/ID-side handshake and ID/EX control bundle of the ID-stage control unit.
interface pipe_control_unit_if #(
  parameter int WORD_LEN     = 32,
  parameter int REG_ADDR_LEN = 5,
  parameter int EXE_FUNC_W   = 3
);
  logic                    instr_valid;
  logic [WORD_LEN-1:0]     instruction;
  logic                    flush;
  logic                    instr_ready;
  logic                    ex_valid;
  logic                    ex_WB_en;
  logic                    ex_MEM_read;
  logic                    ex_MEM_write;
  logic [EXE_FUNC_W-1:0]   ex_EXE_function;
  logic [1:0]              ex_is_br;
  logic                    ex_use_imm;
  logic [REG_ADDR_LEN-1:0] ex_dest;
  logic                    ex_illegal;
  logic                    mul_busy;

  modport master (
    output instr_valid, instruction, flush,
    input  instr_ready, ex_valid, ex_WB_en, ex_MEM_read, ex_MEM_write, ex_EXE_function,
           ex_is_br, ex_use_imm, ex_dest, ex_illegal, mul_busy
  );
  modport slave (
    input  instr_valid, instruction, flush,
    output instr_ready, ex_valid, ex_WB_en, ex_MEM_read, ex_MEM_write, ex_EXE_function,
           ex_is_br, ex_use_imm, ex_dest, ex_illegal, mul_busy
  );
endinterface

// File: rtl/pipe_control_unit_control_decode.sv
// Pure combinational decode table: instruction -> control bundle, rt-read flag,
// MUL flag and illegal flag. Illegal encodings leave every other control at 0.
module control_decode
  import pipe_control_unit_pkg::*;
#(
  parameter int WORD_LEN     = 32,
  parameter int REG_ADDR_LEN = 5,
  parameter int EXE_FUNC_W   = 3,
  parameter bit EN_MUL       = 1'b1
) (
  input  logic [WORD_LEN-1:0]     instruction,
  output logic                    wb_en,
  output logic                    mem_read,
  output logic                    mem_write,
  output logic [EXE_FUNC_W-1:0]   exe_func,
  output logic [1:0]              is_br,
  output logic                    use_imm,
  output logic [REG_ADDR_LEN-1:0] dest,
  output logic                    reads_rt,
  output logic                    is_mul,
  output logic                    illegal
);
  logic [5:0] op, funct;
  logic [4:0] rt, rd;
  logic       wb_raw, ok;
  exe_func_e  func;
  br_e        br;
  logic       unused_bits;

  assign op          = instruction[31:26];
  assign rt          = instruction[20:16];
  assign rd          = instruction[15:11];
  assign funct       = instruction[5:0];
  assign unused_bits = ^instruction[10:6];

  always_comb begin
    wb_raw = 1'b0; mem_read = 1'b0; mem_write = 1'b0; func = EXE_ADD; br = BR_NONE;
    use_imm = 1'b0; dest = '0; reads_rt = 1'b0; is_mul = 1'b0; illegal = 1'b0; ok = 1'b0;
    case (op)
      OP_RTYPE: begin
        reads_rt = 1'b1;
        case (funct)
          FN_ADD: begin func = EXE_ADD; ok = 1'b1; end
          FN_SUB: begin func = EXE_SUB; ok = 1'b1; end
          FN_AND: begin func = EXE_AND; ok = 1'b1; end
          FN_OR:  begin func = EXE_OR;  ok = 1'b1; end
          FN_SLT: begin func = EXE_SLT; ok = 1'b1; end
          FN_MUL: if (EN_MUL) begin func = EXE_MUL; ok = 1'b1; is_mul = 1'b1; end
          default: ;
        endcase
        if (ok) begin wb_raw = 1'b1; dest = REG_ADDR_LEN'(rd); end
        else    illegal = 1'b1;
      end
      OP_ADDI: begin wb_raw = 1'b1; use_imm = 1'b1; dest = REG_ADDR_LEN'(rt); end
      OP_LW:   begin wb_raw = 1'b1; mem_read = 1'b1; use_imm = 1'b1; dest = REG_ADDR_LEN'(rt); end
      OP_SW:   begin mem_write = 1'b1; use_imm = 1'b1; reads_rt = 1'b1; end
      OP_J:    br = BR_JMP;
      OP_BEQ:  begin br = BR_BEQ; func = EXE_SUB; reads_rt = 1'b1; end
      OP_BNE:  begin br = BR_BNE; func = EXE_SUB; reads_rt = 1'b1; end
      default: illegal = 1'b1;
    endcase
  end

  // r0 is hardwired: never request a write to it
  assign wb_en    = wb_raw & (|dest);
  assign exe_func = EXE_FUNC_W'(func);
  assign is_br    = br;
endmodule

// File: rtl/pipe_control_unit.sv
// ID-stage control: load-use hazard check, MULT sequencing FSM and the ID/EX
// control register. Flush overrides everything and always inserts a bubble.
module pipe_control_unit
  import pipe_control_unit_pkg::*;
#(
  parameter int WORD_LEN     = 32,
  parameter int REG_ADDR_LEN = 5,
  parameter int EXE_FUNC_W   = 3,
  parameter bit EN_MUL       = 1'b1,
  parameter int MUL_LATENCY  = 4
) (
  input logic               clk,
  input logic               rst_n,
  pipe_control_unit_if.slave bus
);
  localparam int CNT_W    = $clog2(MUL_LATENCY + 1);
  localparam int CNT_INIT = (MUL_LATENCY > 1) ? MUL_LATENCY - 2 : 0;

  typedef struct packed {
    logic                    valid;
    logic                    wb_en;
    logic                    mem_read;
    logic                    mem_write;
    logic [EXE_FUNC_W-1:0]   func;
    logic [1:0]              is_br;
    logic                    use_imm;
    logic [REG_ADDR_LEN-1:0] dest;
    logic                    illegal;
  } ex_t;

  ex_t                     ex_q, ex_d;
  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    d_wb, d_mr, d_mw, d_use_imm, d_reads_rt, d_is_mul, d_illegal;
  logic [EXE_FUNC_W-1:0]   d_func;
  logic [1:0]              d_br;
  logic [REG_ADDR_LEN-1:0] d_dest, rs, rt;
  logic                    hazard, ready, accept;

  control_decode #(
    .WORD_LEN(WORD_LEN), .REG_ADDR_LEN(REG_ADDR_LEN), .EXE_FUNC_W(EXE_FUNC_W), .EN_MUL(EN_MUL)
  ) u_decode (
    .instruction(bus.instruction), .wb_en(d_wb), .mem_read(d_mr), .mem_write(d_mw),
    .exe_func(d_func), .is_br(d_br), .use_imm(d_use_imm), .dest(d_dest),
    .reads_rt(d_reads_rt), .is_mul(d_is_mul), .illegal(d_illegal)
  );

  assign rs = REG_ADDR_LEN'(bus.instruction[25:21]);
  assign rt = REG_ADDR_LEN'(bus.instruction[20:16]);

  // A load in EXE cannot forward to ID in time; hold ID for one bubble
  assign hazard = ex_q.valid & ex_q.mem_read & (|ex_q.dest) &
                  ((ex_q.dest == rs) | (d_reads_rt & (ex_q.dest == rt)));
  assign ready  = (state_q == ST_RUN) & ~hazard;
  assign accept = bus.instr_valid & ready & ~bus.flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (bus.flush) begin
      state_d = ST_RUN;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_RUN:
          if (accept && d_is_mul && (MUL_LATENCY > 1)) begin
            state_d = ST_MUL_WAIT;
            cnt_d   = CNT_W'(CNT_INIT);
          end
        ST_MUL_WAIT:
          if (cnt_q == '0) state_d = ST_RUN;
          else             cnt_d   = cnt_q - CNT_W'(1);
        default: state_d = ST_RUN;
      endcase
    end
  end

  always_comb begin
    bus.instr_ready = ready;
    bus.mul_busy    = (state_q == ST_MUL_WAIT);
  end

  always_comb begin
    ex_d = '0;
    if (accept) begin
      ex_d.valid     = 1'b1;
      ex_d.wb_en     = d_wb;
      ex_d.mem_read  = d_mr;
      ex_d.mem_write = d_mw;
      ex_d.func      = d_func;
      ex_d.is_br     = d_br;
      ex_d.use_imm   = d_use_imm;
      ex_d.dest      = d_dest;
      ex_d.illegal   = d_illegal;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ex_q <= '0;
    else        ex_q <= ex_d;
  end

  assign bus.ex_valid        = ex_q.valid;
  assign bus.ex_WB_en        = ex_q.wb_en;
  assign bus.ex_MEM_read     = ex_q.mem_read;
  assign bus.ex_MEM_write    = ex_q.mem_write;
  assign bus.ex_EXE_function = ex_q.func;
  assign bus.ex_is_br        = ex_q.is_br;
  assign bus.ex_use_imm      = ex_q.use_imm;
  assign bus.ex_dest         = ex_q.dest;
  assign bus.ex_illegal      = ex_q.illegal;
endmodule

// File: tb/tb_pipe_control_unit.sv
// Drives one stimulus stream into a MUL-enabled and a MUL-disabled unit and checks
// both every cycle against an instruction-level model, plus literal directed checks.
module tb_pipe_control_unit;
  localparam int LAT = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pipe_control_unit_if bus0 ();
  pipe_control_unit_if bus1 ();

  pipe_control_unit #(.EN_MUL(1'b0), .MUL_LATENCY(LAT)) u_nomul (.clk(clk), .rst_n(rst_n), .bus(bus0));
  pipe_control_unit #(.EN_MUL(1'b1), .MUL_LATENCY(LAT)) u_mul   (.clk(clk), .rst_n(rst_n), .bus(bus1));

  typedef struct packed {
    logic       valid, wb, mr, mw;
    logic [2:0] func;
    logic [1:0] br;
    logic       imm;
    logic [4:0] dest;
    logic       ill, busy;
  } obs_t;

  obs_t obs[2];
  logic rdy[2];
  assign obs[0] = {bus0.ex_valid, bus0.ex_WB_en, bus0.ex_MEM_read, bus0.ex_MEM_write, bus0.ex_EXE_function,
                   bus0.ex_is_br, bus0.ex_use_imm, bus0.ex_dest, bus0.ex_illegal, bus0.mul_busy};
  assign obs[1] = {bus1.ex_valid, bus1.ex_WB_en, bus1.ex_MEM_read, bus1.ex_MEM_write, bus1.ex_EXE_function,
                   bus1.ex_is_br, bus1.ex_use_imm, bus1.ex_dest, bus1.ex_illegal, bus1.mul_busy};
  assign rdy[0] = bus0.instr_ready;
  assign rdy[1] = bus1.instr_ready;

  typedef struct {int valid, wb, mr, mw, func, br, imm, dest, ill;} exm_t;

  int   tests = 0, fails = 0;
  exm_t mex[2];
  int   stall[2];
  bit   exp_rdy[2];
  logic got_rdy[2];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic exm_t bubble();
    exm_t b;
    b = '{default: 0};
    return b;
  endfunction

  // Instruction-level decode straight from the ISA table
  function automatic exm_t ref_decode(logic [31:0] ins, bit en_mul);
    exm_t d;
    int op, rt, rd, fn;
    d = bubble();
    op = int'(ins[31:26]); rt = int'(ins[20:16]); rd = int'(ins[15:11]); fn = int'(ins[5:0]);
    d.valid = 1;
    case (op)
      0: begin
        case (fn)
          'h20: d.func = 0;
          'h22: d.func = 1;
          'h24: d.func = 2;
          'h25: d.func = 3;
          'h2a: d.func = 4;
          'h18: d.func = en_mul ? 5 : -1;
          default: d.func = -1;
        endcase
        if (d.func < 0) begin d.func = 0; d.ill = 1; end
        else begin d.wb = 1; d.dest = rd; end
      end
      'h08: begin d.wb = 1; d.imm = 1; d.dest = rt; end
      'h23: begin d.wb = 1; d.mr = 1; d.imm = 1; d.dest = rt; end
      'h2b: begin d.mw = 1; d.imm = 1; end
      'h02: d.br = 1;
      'h04: begin d.br = 2; d.func = 1; end
      'h05: begin d.br = 3; d.func = 1; end
      default: d.ill = 1;
    endcase
    if (d.dest == 0) d.wb = 0;
    return d;
  endfunction

  function automatic bit m_ready(int m, logic [31:0] ins);
    int op, rs, rt;
    bit rrt;
    op = int'(ins[31:26]); rs = int'(ins[25:21]); rt = int'(ins[20:16]);
    rrt = (op == 0) || (op == 'h2b) || (op == 'h04) || (op == 'h05);
    if (stall[m] != 0) return 1'b0;
    if (mex[m].valid != 0 && mex[m].mr != 0 && mex[m].dest != 0 &&
        (mex[m].dest == rs || (rrt && mex[m].dest == rt))) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_step(int m, bit v, logic [31:0] ins, bit fl, bit r);
    if (fl) begin
      mex[m] = bubble(); stall[m] = 0;
    end else if (v && r) begin
      mex[m] = ref_decode(ins, m == 1);
      if (mex[m].func == 5 && mex[m].ill == 0 && LAT > 1) stall[m] = LAT - 1;
    end else begin
      mex[m] = bubble();
      if (stall[m] > 0) stall[m]--;
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin mex[m] = bubble(); stall[m] = 0; end
  endtask

  task automatic check_ex();
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("u%0d ex_valid", m),   obs[m].valid, mex[m].valid);
      chk($sformatf("u%0d ex_WB_en", m),   obs[m].wb,    mex[m].wb);
      chk($sformatf("u%0d ex_MEM_read", m),  obs[m].mr,  mex[m].mr);
      chk($sformatf("u%0d ex_MEM_write", m), obs[m].mw,  mex[m].mw);
      chk($sformatf("u%0d ex_EXE_function", m), obs[m].func, mex[m].func);
      chk($sformatf("u%0d ex_is_br", m),   obs[m].br,    mex[m].br);
      chk($sformatf("u%0d ex_use_imm", m), obs[m].imm,   mex[m].imm);
      chk($sformatf("u%0d ex_dest", m),    obs[m].dest,  mex[m].dest);
      chk($sformatf("u%0d ex_illegal", m), obs[m].ill,   mex[m].ill);
      chk($sformatf("u%0d mul_busy", m),   obs[m].busy,  (stall[m] > 0) ? 1 : 0);
    end
  endtask

  // One cycle, entered and left at a falling edge
  task automatic cycle(bit v, logic [31:0] ins, bit fl);
    bus0.instr_valid = v; bus0.instruction = ins; bus0.flush = fl;
    bus1.instr_valid = v; bus1.instruction = ins; bus1.flush = fl;
    #1;
    for (int m = 0; m < 2; m++) begin
      exp_rdy[m] = m_ready(m, ins);
      got_rdy[m] = rdy[m];
      chk($sformatf("u%0d instr_ready", m), rdy[m], exp_rdy[m]);
    end
    @(posedge clk);
    for (int m = 0; m < 2; m++) model_step(m, v, ins, fl, exp_rdy[m]);
    @(negedge clk);
    check_ex();
  endtask

  function automatic logic [31:0] r_ins(logic [4:0] rs, logic [4:0] rt, logic [4:0] rd, logic [5:0] fn);
    return {6'd0, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] i_ins(logic [5:0] op, logic [4:0] rs, logic [4:0] rt, logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] rand_ins();
    logic [5:0] fns[8];
    logic [4:0] a, b, c;
    int k;
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h18, 6'h21, 6'h00};
    a = 5'($urandom_range(0, 5)); b = 5'($urandom_range(0, 5)); c = 5'($urandom_range(0, 5));
    k = int'($urandom_range(0, 9));
    case (k)
      0, 1, 2: return r_ins(a, b, c, fns[$urandom_range(0, 7)]);
      3:       return i_ins(6'h08, a, b, 16'($urandom));
      4, 5:    return i_ins(6'h23, a, b, 16'($urandom));
      6:       return i_ins(6'h2b, a, b, 16'($urandom));
      7:       return {6'h02, 26'($urandom)};
      8:       return i_ins(($urandom_range(0, 1) != 0) ? 6'h04 : 6'h05, a, b, 16'($urandom));
      default: return $urandom;
    endcase
  endfunction

  localparam logic [5:0] ADD = 6'h20;
  localparam logic [5:0] MUL = 6'h18;

  initial begin
    int n;
    logic nomul_rdy;
    rst_n = 1'b0;
    bus0.instr_valid = 1'b0; bus0.instruction = '0; bus0.flush = 1'b0;
    bus1.instr_valid = 1'b0; bus1.instruction = '0; bus1.flush = 1'b0;
    model_reset();
    @(negedge clk);
    check_ex();
    chk("reset instr_ready", rdy[1], 1);
    rst_n = 1'b1;

    cycle(1, 32'h00221820, 0);
    chk("add func", obs[1].func, 0); chk("add dest", obs[1].dest, 3); chk("add imm", obs[1].imm, 0);
    cycle(1, i_ins(6'h08, 0, 4, 5), 0);
    chk("addi dest", obs[1].dest, 4); chk("addi imm", obs[1].imm, 1); chk("addi wb", obs[1].wb, 1);

    cycle(1, i_ins(6'h23, 1, 5, 0), 0);
    cycle(1, r_ins(5, 2, 6, ADD), 0);
    chk("load-use ready", got_rdy[1], 0); chk("load-use bubble", obs[1].valid, 0);
    cycle(1, r_ins(5, 2, 6, ADD), 0);
    chk("after bubble ready", got_rdy[1], 1); chk("after bubble dest", obs[1].dest, 6);
    cycle(1, i_ins(6'h23, 1, 5, 0), 0);
    cycle(1, r_ins(1, 2, 6, ADD), 0);
    chk("no-dep ready", got_rdy[1], 1); chk("no-dep valid", obs[1].valid, 1);

    cycle(1, r_ins(1, 2, 7, MUL), 0);
    chk("mul func", obs[1].func, 5); chk("mul busy", obs[1].busy, 1);
    chk("nomul illegal", obs[0].ill, 1); chk("nomul busy", obs[0].busy, 0);
    n = 0; nomul_rdy = 1'b0;
    for (int k = 0; k < 20; k++) begin
      cycle(1, r_ins(1, 2, 3, ADD), 0);
      if (k == 0) nomul_rdy = got_rdy[0];
      if (got_rdy[1]) break;
      n++;
    end
    chk("mul stall cycles", n, LAT - 1);
    chk("nomul no stall", nomul_rdy, 1);

    cycle(1, i_ins(6'h04, 1, 2, 3), 1);
    chk("flush beq u1", obs[1].valid, 0); chk("flush beq u0", obs[0].valid, 0);
    cycle(1, r_ins(1, 2, 7, MUL), 0);
    cycle(0, 32'd0, 1);
    chk("flush mul busy", obs[1].busy, 0);
    cycle(1, r_ins(1, 2, 3, ADD), 0);
    chk("flush mul ready", got_rdy[1], 1);

    cycle(1, 32'hFC00_1234, 0);
    chk("illegal flag", obs[1].ill, 1); chk("illegal wb", obs[1].wb, 0);
    chk("illegal mem", {obs[1].mr, obs[1].mw}, 0); chk("illegal br", obs[1].br, 0);
    cycle(1, r_ins(1, 2, 0, ADD), 0);
    chk("rd0 wb", obs[1].wb, 0); chk("rd0 valid", obs[1].valid, 1);

    cycle(1, r_ins(1, 2, 7, MUL), 0);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset outputs", obs[1], 0);
    chk("midreset ready", rdy[1], 1);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    for (int c = 0; c < 3000; c++)
      cycle(($urandom_range(0, 3) != 0), rand_ins(), ($urandom_range(0, 9) == 0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
